// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the per-stage shift distance helper.
package barrel_shifter_pkg;

  // Operation encodings carried on in_mode; 101..111 pass data through.
  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;

  // Stages are ordered MSB first, so stage k of n handles weight 2^(n-1-k).
  function automatic int shift_dist(input int k, input int n);
    return 1 << (n - 1 - k);
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One binary-weighted shifter stage: shifts by DIST when its shamt bit is set,
// updates the carry-out, and registers the result behind a valid/ready slot.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int DIST  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [2:0]               in_mode,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic                     in_sign,
  input  logic                     in_carry,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [2:0]               out_mode,
  output logic [$clog2(WIDTH)-1:0] out_shamt,
  output logic                     out_sign,
  output logic                     out_carry,
  output logic [TAG_W-1:0]         out_tag
);

  // Shamt bit this stage is responsible for.
  localparam int BIT = $clog2(DIST);

  logic [WIDTH-1:0]         shifted;
  logic                     carry_next;
  logic                     valid_reg;
  logic [WIDTH-1:0]         data_reg;
  logic [2:0]               mode_reg;
  logic [$clog2(WIDTH)-1:0] shamt_reg;
  logic                     sign_reg;
  logic                     carry_reg;
  logic [TAG_W-1:0]         tag_reg;

  // Shift by DIST when selected; the carry is only replaced by a stage that
  // really shifts, so shamt 0 and reserved modes keep the incoming 0.
  always_comb begin
    shifted    = in_data;
    carry_next = in_carry;
    if (in_shamt[BIT]) begin
      case (in_mode)
        MODE_LSL: begin
          shifted    = in_data << DIST;
          carry_next = in_data[WIDTH-DIST];
        end
        MODE_LSR: begin
          shifted    = in_data >> DIST;
          carry_next = in_data[DIST-1];
        end
        MODE_ASR: begin
          // Fill from the latched original MSB, not this stage's MSB.
          shifted    = {{DIST{in_sign}}, in_data[WIDTH-1:DIST]};
          carry_next = in_data[DIST-1];
        end
        MODE_ROR: begin
          shifted    = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
          carry_next = in_data[DIST-1];
        end
        MODE_ROL: begin
          shifted    = {in_data[WIDTH-DIST-1:0], in_data[WIDTH-1:WIDTH-DIST]};
          carry_next = in_data[WIDTH-DIST];
        end
        default: begin
          shifted    = in_data;
          carry_next = in_carry;
        end
      endcase
    end
  end

  // Pipeline slot: loads whenever this stage is ready, otherwise holds every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      mode_reg  <= '0;
      shamt_reg <= '0;
      sign_reg  <= 1'b0;
      carry_reg <= 1'b0;
      tag_reg   <= '0;
    end else if (ready) begin
      valid_reg <= in_valid;
      data_reg  <= shifted;
      mode_reg  <= in_mode;
      shamt_reg <= in_shamt;
      sign_reg  <= in_sign;
      carry_reg <= carry_next;
      tag_reg   <= in_tag;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_mode  = mode_reg;
  assign out_shamt = shamt_reg;
  assign out_sign  = sign_reg;
  assign out_carry = carry_reg;
  assign out_tag   = tag_reg;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR/ROL) with one registered stage per
// shamt bit, a combinational ready chain, and a pass-through tag.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [2:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_carry,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int N       = SHAMT_W;

  // Index 0 is the input port; index k+1 is the register of stage k.
  logic                 valid_s     [0:N];
  logic [WIDTH-1:0]     data_s      [0:N];
  logic [2:0]           mode_s      [0:N];
  logic [SHAMT_W-1:0]   shamt_s     [0:N];
  logic                 sign_s      [0:N];
  logic                 carry_s     [0:N];
  logic [TAG_W-1:0]     tag_s       [0:N];
  logic                 stage_ready [0:N];

  assign valid_s[0]     = in_valid;
  assign data_s[0]      = in_data;
  assign mode_s[0]      = in_mode;
  assign shamt_s[0]     = in_shamt;
  assign sign_s[0]      = in_data[WIDTH-1];
  assign carry_s[0]     = 1'b0;
  assign tag_s[0]       = in_tag;
  assign stage_ready[N] = out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      // An empty stage always accepts, so bubbles collapse under a stall.
      assign stage_ready[gi] = ~valid_s[gi+1] | stage_ready[gi+1];

      barrel_shift_stage #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W),
        .DIST  (shift_dist(gi, N))
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .ready     (stage_ready[gi]),
        .in_valid  (valid_s[gi]),
        .in_data   (data_s[gi]),
        .in_mode   (mode_s[gi]),
        .in_shamt  (shamt_s[gi]),
        .in_sign   (sign_s[gi]),
        .in_carry  (carry_s[gi]),
        .in_tag    (tag_s[gi]),
        .out_valid (valid_s[gi+1]),
        .out_data  (data_s[gi+1]),
        .out_mode  (mode_s[gi+1]),
        .out_shamt (shamt_s[gi+1]),
        .out_sign  (sign_s[gi+1]),
        .out_carry (carry_s[gi+1]),
        .out_tag   (tag_s[gi+1])
      );
    end
  endgenerate

  assign in_ready  = stage_ready[0];
  assign out_valid = valid_s[N];
  assign out_data  = data_s[N];
  assign out_carry = carry_s[N];
  assign out_tag   = tag_s[N];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: directed cases on 8- and 32-bit
// instances plus random streams scored against a behavioural model.
module tb_barrel_shifter_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int N  = 5;
  localparam int N8 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic          in_valid, in_ready, out_valid, out_ready, out_carry;
  logic [W-1:0]  in_data, out_data;
  logic [4:0]    in_shamt;
  logic [2:0]    in_mode;
  logic [TW-1:0] in_tag, out_tag;

  // 8-bit instance
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_carry;
  logic [7:0]    a_in_data, a_out_data;
  logic [2:0]    a_in_shamt;
  logic [2:0]    a_in_mode;
  logic [TW-1:0] a_in_tag, a_out_tag;

  barrel_shifter_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_tag(out_tag)
  );

  barrel_shifter_pipe #(.WIDTH(8), .TAG_W(TW)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shamt(a_in_shamt), .in_mode(a_in_mode), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_carry(a_out_carry), .out_tag(a_out_tag)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic          carry;
    logic [TW-1:0] tag;
    int            acc;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit lat_check = 1'b1;
  bit got = 1'b0;
  logic [W-1:0] last_data;
  logic last_carry;
  int out_count = 0;
  int first_out_cyc = 0;
  int last_out_cyc = 0;
  bit hold_prev = 1'b0;
  logic [W-1:0] hold_data;
  logic hold_carry;
  logic [TW-1:0] hold_tag;

  // Reference: whole-operation shift computed directly from the mode rules.
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [4:0] sh, input logic [2:0] m);
    logic [W-1:0]   r;
    logic           c;
    logic [2*W-1:0] dd;
    int s;
    s  = int'(sh);
    dd = {d, d};
    r  = d;
    c  = 1'b0;
    case (m)
      3'd0: begin r = d << s; if (s != 0) c = d[W-s]; end
      3'd1: begin r = d >> s; if (s != 0) c = d[s-1]; end
      3'd2: begin r = $signed(d) >>> s; if (s != 0) c = d[s-1]; end
      3'd3: begin dd = dd >> s; r = dd[W-1:0]; if (s != 0) c = r[W-1]; end
      3'd4: begin dd = dd << s; r = dd[2*W-1:W]; if (s != 0) c = r[0]; end
      default: begin r = d; c = 1'b0; end
    endcase
    return {c, r};
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
  endtask

  // One clock: score handshakes in the settled pre-edge window, then advance.
  task automatic cycle();
    logic [W:0] r;
    exp_t e;
    #1;
    if (!rst) begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_carry", out_carry, hold_carry);
        check("hold_tag", out_tag, hold_tag);
      end
      if (in_valid && in_ready) begin
        r = model(in_data, in_shamt, in_mode);
        e.data = r[W-1:0];
        e.carry = r[W];
        e.tag = in_tag;
        e.acc = cyc;
        q.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          $display("out tag=%h data=%h carry=%b cyc=%0d", out_tag, out_data, out_carry, cyc);
          check("data", out_data, e.data);
          check("carry", out_carry, e.carry);
          check("tag", out_tag, e.tag);
          if (lat_check) check("latency", cyc - e.acc, N);
          if (out_count == 0) first_out_cyc = cyc;
          last_out_cyc = cyc;
          out_count = out_count + 1;
          got = 1'b1;
          last_data = out_data;
          last_carry = out_carry;
        end
      end
      hold_prev  = out_valid && !out_ready;
      hold_data  = out_data;
      hold_carry = out_carry;
      hold_tag   = out_tag;
    end else begin
      hold_prev = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic send32(input logic [W-1:0] d, input logic [4:0] s, input logic [2:0] m, input logic [TW-1:0] t);
    int waited;
    waited = 0;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m; in_tag = t;
    while (!in_ready && waited < 50) begin
      cycle();
      waited++;
    end
    if (waited >= 50) check("send_timeout", waited, 0);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      cycle();
      k++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic await_result(input string name, input logic [W-1:0] d, input logic c);
    int k;
    k = 0;
    while (!got && k < 20) begin
      cycle();
      k++;
    end
    check({name, "_seen"}, got, 1);
    check({name, "_data"}, last_data, d);
    check({name, "_carry"}, last_carry, c);
    got = 1'b0;
  endtask

  // Directed op on the 8-bit instance with an exact latency check.
  task automatic run8(input string name, input logic [7:0] d, input logic [2:0] s, input logic [2:0] m,
                      input logic [TW-1:0] t, input logic [7:0] exp_d, input logic exp_c);
    a_in_valid = 1'b1; a_in_data = d; a_in_shamt = s; a_in_mode = m; a_in_tag = t;
    check({name, "_in_ready"}, a_in_ready, 1);
    cycle();
    a_in_valid = 1'b0;
    for (int i = 0; i < N8 - 1; i++) begin
      check({name, "_early"}, a_out_valid, 0);
      cycle();
    end
    check({name, "_valid"}, a_out_valid, 1);
    check({name, "_data"}, a_out_data, exp_d);
    check({name, "_carry"}, a_out_carry, exp_c);
    check({name, "_tag"}, a_out_tag, t);
    $display("out8 tag=%h data=%h carry=%b", a_out_tag, a_out_data, a_out_carry);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=hang required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int filled;
    int outs0;
    logic [W-1:0] sd;
    logic sc;
    logic [TW-1:0] st;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_mode = '0; a_in_tag = '0; a_out_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_carry", out_carry, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid8", a_out_valid, 0);

    // 8-bit directed: LSL, reserved mode, shamt 0
    run8("lsl8", 8'h96, 3'd3, 3'b000, 4'h1, 8'hB0, 1'b0);
    run8("rsv8", 8'h5A, 3'd5, 3'b110, 4'h2, 8'h5A, 1'b0);
    run8("sh0_8", 8'hFF, 3'd0, 3'b000, 4'h3, 8'hFF, 1'b0);

    // 32-bit directed boundaries
    got = 1'b0;
    send32(32'h8000_0001, 5'd31, 3'b010, 4'h4);
    await_result("asr31", 32'hFFFF_FFFF, 1'b0);
    send32(32'h8000_0001, 5'd1, 3'b011, 4'h5);
    await_result("ror1", 32'hC000_0000, 1'b1);
    send32(32'h8000_0001, 5'd31, 3'b000, 4'h6);
    await_result("lsl31", 32'h8000_0000, 1'b0);
    send32(32'h0000_5A5A, 5'd9, 3'b111, 4'h7);
    await_result("rsv32", 32'h0000_5A5A, 1'b0);

    // Back-to-back random stream
    out_count = 0;
    c0 = cyc;
    for (int i = 0; i < 16; i++)
      send32($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 4'(i));
    check("b2b_accept_cycles", cyc - c0, 16);
    drain();
    check("b2b_out_count", out_count, 16);
    check("b2b_consecutive", last_out_cyc - first_out_cyc, 15);

    // Stall: fill with out_ready low, hold, release
    lat_check = 1'b0;
    out_ready = 1'b0;
    filled = 0;
    outs0 = out_count;
    for (int i = 0; i < N + 2; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom_range(0, 31));
      in_mode = 3'($urandom_range(0, 4)); in_tag = 4'(8 + i);
      if (!in_ready) break;
      cycle();
      filled++;
    end
    check("fill_count", filled, N);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    sd = out_data; sc = out_carry; st = out_tag;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_in_ready", in_ready, 0);
      check("stall_data", out_data, sd);
      check("stall_carry", out_carry, sc);
      check("stall_tag", out_tag, st);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    cycle();
    in_valid = 1'b0;
    drain();
    check("stall_out_count", out_count - outs0, N + 1);

    // Random traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom; in_shamt = 5'($urandom_range(0, 31));
      in_mode = 3'($urandom_range(0, 7)); in_tag = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with three ops in flight; an op presented during reset is dropped
    lat_check = 1'b1;
    for (int i = 0; i < 3; i++)
      send32($urandom, 5'($urandom_range(1, 31)), 3'($urandom_range(0, 4)), 4'(12 + i));
    rst = 1'b1;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_shamt = 5'd4; in_mode = 3'b001; in_tag = 4'hF;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    q.delete();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) cycle();
    got = 1'b0;
    send32(32'h0000_00F0, 5'd4, 3'b001, 4'h9);
    await_result("post_rst_lsr", 32'h0000_000F, 1'b0);
    check("final_queue", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
